// File: rtl/cdc_fifo_read_arbiter.sv
// Round-robin, burst-granular arbiter sharing a FIFO read port among NUM_REQ consumers.
// One burst of up to BURST_MAX words per grant, with early release on withdrawn request or prolonged empty.
module cdc_fifo_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_MAX   = 4,
  parameter int EMPTY_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_increment,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  fsm_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int EW = $clog2(EMPTY_LIMIT + 1);
  localparam logic [BW-1:0] LAST_CNT  = BW'(BURST_MAX - 1);
  localparam logic [EW-1:0] EMPTY_END = EW'(EMPTY_LIMIT - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Handshake: a word moves to consumer g on a cycle where out_valid and ready[g] are both high;
  // that same cycle pops the FIFO. out_valid never depends on ready.
  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant_q, grant_nxt;
  logic [PW-1:0]       rr_ptr, rr_nxt, sel;
  logic [BW-1:0]       burst_cnt, burst_nxt;
  logic [EW-1:0]       empty_cnt, empty_nxt;
  logic                req_g, ready_g;

  // rr_ptr holds the granted index for the whole burst, since it only moves at grant time.
  assign req_g     = req[rr_ptr];
  assign ready_g   = ready[rr_ptr];
  assign grant     = grant_q;
  assign out_data  = fifo_read_data;
  assign fsm_state = (state == BURST);

  always_comb begin : sel_search
    logic [PW-1:0] cand;
    logic          found;
    cand  = '0;
    found = 1'b0;
    sel   = rr_ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    rr_nxt         = rr_ptr;
    burst_nxt      = burst_cnt;
    empty_nxt      = empty_cnt;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    fifo_increment = 1'b0;
    case (state)
      IDLE: begin
        if (|req && !fifo_empty) begin
          state_nxt = BURST;
          grant_nxt = NUM_REQ'(1) << sel;
          rr_nxt    = sel;
          burst_nxt = '0;
          empty_nxt = '0;
        end
      end
      BURST: begin
        // Gating with reset keeps the FIFO from popping in a reset cycle.
        out_valid      = !fifo_empty && req_g && !reset;
        out_last       = out_valid && (burst_cnt == LAST_CNT);
        fifo_increment = out_valid && ready_g;
        if (!req_g) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (fifo_increment) begin
          burst_nxt = burst_cnt + 1'b1;
          if (out_last) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end else if (fifo_empty) begin
          if (empty_cnt == EMPTY_END) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end else begin
            empty_nxt = empty_cnt + 1'b1;
          end
        end
        if (!fifo_empty) empty_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q   <= '0;
      rr_ptr    <= PW'(NUM_REQ - 1);
      burst_cnt <= '0;
      empty_cnt <= '0;
    end else begin
      grant_q   <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
      empty_cnt <= empty_nxt;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_read_arbiter.sv
// Bench for cdc_fifo_read_arbiter: hand-derived vector table, directed corner sequences,
// and randomized traffic against a consumer-level reference model.
module tb_cdc_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int EL = 8;

  logic          clock, reset, fifo_empty, fifo_increment;
  logic [DW-1:0] fifo_read_data, out_data;
  logic [N-1:0]  req, ready, grant;
  logic          out_valid, out_last, fsm_state;

  cdc_fifo_read_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM), .EMPTY_LIMIT(EL)
  ) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_increment(fifo_increment), .req(req), .ready(ready), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .fsm_state(fsm_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            grant_log[$];
  logic [N-1:0]  prev_grant = '0;

  // Reference model: owner is the consumer holding the port (-1 when free),
  // last_win the most recent winner, words/empties the progress of the current burst.
  int   m_owner = -1, m_last = N - 1, m_words = 0, m_empties = 0;
  logic m_valid, m_xfer, m_lastw;
  logic [N-1:0] m_grant;

  logic [N-1:0]  s_grant;
  logic          s_valid, s_inc, s_last;
  logic [DW-1:0] s_data;

  typedef struct {
    logic         rst;
    logic [N-1:0] r;
    logic [N-1:0] rd;
    int           push;
    logic [N-1:0] g;
    logic         v;
    logic         i;
    logic         l;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = DW'($urandom_range(0, 255));
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [N-1:0] rd, input int push);
    logic e;
    logic [DW-1:0] d;
    @(negedge clock);
    push_words(push);
    reset = rst;
    req   = r;
    ready = rd;
    fifo_empty     = (fifo_q.size() == 0);
    fifo_read_data = fifo_empty ? '0 : fifo_q[0];
    e = fifo_empty;
    #1;
    m_grant = '0;
    m_valid = 1'b0;
    m_xfer  = 1'b0;
    if (m_owner >= 0) begin
      m_grant = N'(1) << m_owner;
      m_valid = !e && r[m_owner] && !rst;
      m_xfer  = m_valid && rd[m_owner];
    end
    m_lastw = m_valid && (m_words == BM - 1);
    s_grant = grant;
    s_valid = out_valid;
    s_inc   = fifo_increment;
    s_last  = out_last;
    s_data  = out_data;
    chk("grant", grant, m_grant);
    chk("out_valid", out_valid, m_valid);
    chk("fifo_increment", fifo_increment, m_xfer);
    chk("out_last", out_last, m_lastw);
    chk("fsm_state", fsm_state, m_owner >= 0);
    chk("grant_onehot", $countones(grant) <= 1, 1);
    if (fifo_increment) begin
      if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
      else begin
        d = exp_q.pop_front();
        chk("out_data", out_data, d);
      end
    end
    if (grant != '0 && prev_grant == '0) grant_log.push_back($clog2(grant));
    prev_grant = grant;
    @(posedge clock);
    if (s_inc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_words = 0; m_empties = 0;
    end else if (m_owner < 0) begin
      if (r != '0 && !e) begin
        for (int k = 1; k <= N; k++) begin
          if (r[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            m_last = m_owner; m_words = 0; m_empties = 0;
            break;
          end
        end
      end
    end else begin
      if (!r[m_owner]) m_owner = -1;
      else if (m_xfer) begin
        m_words++;
        if (m_words == BM) m_owner = -1;
      end else if (e) begin
        m_empties++;
        if (m_empties == EL) m_owner = -1;
      end
      if (!e) m_empties = 0;
    end
  endtask

  logic [N-1:0]  rnd_req, rnd_rdy;
  logic [DW-1:0] held;
  int            incs;

  initial begin
    reset = 1'b1; req = '0; ready = '0; fifo_empty = 1'b1; fifo_read_data = '0;
    repeat (2) @(posedge clock);

    // Two consumers, eight words: back-to-back bursts with one dead cycle.
    tbl[0] = '{1'b0, 4'b0011, 4'b1111, 8, 4'b0000, 1'b0, 1'b0, 1'b0};
    for (int k = 1; k <= 3; k++) tbl[k] = '{1'b0, 4'b0011, 4'b1111, 0, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'b0011, 4'b1111, 0, 4'b0001, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'b0011, 4'b1111, 0, 4'b0000, 1'b0, 1'b0, 1'b0};
    for (int k = 6; k <= 8; k++) tbl[k] = '{1'b0, 4'b0011, 4'b1111, 0, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0011, 4'b1111, 0, 4'b0010, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'b0011, 4'b1111, 0, 4'b0000, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].rst, tbl[k].r, tbl[k].rd, tbl[k].push);
      chk($sformatf("tbl%0d_grant", k), s_grant, tbl[k].g);
      chk($sformatf("tbl%0d_valid", k), s_valid, tbl[k].v);
      chk($sformatf("tbl%0d_inc", k), s_inc, tbl[k].i);
      chk($sformatf("tbl%0d_last", k), s_last, tbl[k].l);
    end

    // Early release: req1 withdraws after two words, pending req2 gets the next burst.
    cycle(1'b0, 4'b0010, 4'b1111, 8);
    cycle(1'b0, 4'b0010, 4'b1111, 0);
    cycle(1'b0, 4'b0010, 4'b1111, 0);
    cycle(1'b0, 4'b0100, 4'b1111, 0);
    chk("t5_no_last", s_last, 1'b0);
    cycle(1'b0, 4'b0100, 4'b1111, 0);
    chk("t5_released", s_grant, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 4'b0100, 4'b1111, 0);
      chk("t5_next_grant", s_grant, 4'b0100);
    end

    // Consumer stall: ready low for three cycles after the first word.
    incs = 0;
    cycle(1'b0, 4'b0100, 4'b1111, 6);
    cycle(1'b0, 4'b0100, 4'b0100, 0);
    incs += int'(s_inc);
    held = fifo_q[0];
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'b0100, 4'b1011, 0);
      chk("t3_hold_inc", s_inc, 1'b0);
      chk("t3_hold_data", s_data, held);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 4'b0100, 4'b0100, 0);
      incs += int'(s_inc);
    end
    chk("t3_words", incs, 4);
    chk("t3_released", s_grant, 4'b0000);

    // FIFO runs dry two words into a burst.
    for (int k = 0; k < 40 && fifo_q.size() != 0; k++) cycle(1'b0, 4'b0001, 4'b1111, 0);
    chk("drain_done", fifo_q.size(), 0);
    cycle(1'b0, 4'b0000, 4'b0000, 0);
    cycle(1'b0, 4'b0001, 4'b1111, 2);
    cycle(1'b0, 4'b0001, 4'b1111, 0);
    cycle(1'b0, 4'b0001, 4'b1111, 0);
    for (int k = 0; k < EL; k++) begin
      cycle(1'b0, 4'b0001, 4'b1111, 0);
      chk("t4_grant_held", s_grant, 4'b0001);
      chk("t4_no_inc", s_inc, 1'b0);
    end
    cycle(1'b0, 4'b0001, 4'b1111, 0);
    chk("t4_released", s_grant, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000, 0);

    // Reset mid-burst, then full round-robin rotation over 32 words.
    cycle(1'b0, 4'b1111, 4'b1111, 8);
    cycle(1'b0, 4'b1111, 4'b1111, 0);
    cycle(1'b0, 4'b1111, 4'b1111, 0);
    cycle(1'b1, 4'b1111, 4'b1111, 0);
    chk("t6_no_pop_in_reset", s_inc, 1'b0);
    grant_log.delete();
    cycle(1'b0, 4'b1111, 4'b1111, 26);
    chk("t6_grant_dropped", s_grant, 4'b0000);
    chk("t6_no_inc_after", s_inc, 1'b0);
    cycle(1'b0, 4'b1111, 4'b1111, 0);
    chk("t6_first_grant", s_grant, 4'b0001);
    for (int k = 0; k < 41; k++) cycle(1'b0, 4'b1111, 4'b1111, 0);
    chk("t2_bursts", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk($sformatf("t2_order%0d", k), grant_log[k], k % 4);

    // Randomized traffic with alternating busy and dry phases.
    rnd_req = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = N'($urandom_range(0, 15));
      rnd_rdy = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
      cycle(($urandom_range(0, 149) == 0), rnd_req, rnd_rdy,
            ($urandom_range(0, ((k % 100) < 50) ? 1 : 12) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
